// File: rtl/char_row_scheduler.sv
// Character-row scheduler: fetches cell words, drives the character generator and
// serialises one 8-pixel row per cell, prefetching one cell ahead for gapless output.
module char_row_scheduler #(
    parameter int COLUMNS    = 40,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [ADDR_WIDTH-1:0] row_addr,
    input  logic [3:0]            line_in_row,
    input  logic                  lower_half,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data,
    output logic [7:0]            cg_character_index,
    output logic [3:0]            cg_ychar,
    output logic                  cg_xsize,
    output logic                  cg_ysize,
    output logic                  cg_xpart,
    output logic                  cg_ypart,
    output logic                  cg_underline,
    output logic                  cg_invert,
    output logic                  cg_load,
    input  logic [7:0]            cg_row_pixels,
    output logic                  pixel,
    output logic                  pixel_valid,
    output logic                  busy,
    output logic                  line_done
);

    typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DONE} state_t;

    localparam logic [7:0] COLS = 8'(COLUMNS);

    state_t                state_q, state_d;
    logic [2:0]            slot_q, slot_d;
    logic [7:0]            col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [3:0]            line_q, line_d;
    logic                  lower_q, lower_d;
    logic [7:0]            idx_q, idx_d;
    logic                  xsize_q, xsize_d;
    logic                  ysize_q, ysize_d;
    logic                  uline_q, uline_d;
    logic                  inv_q, inv_d;
    logic                  xpart_q, xpart_d;
    logic                  right_pend_q, right_pend_d;
    logic [7:0]            pending_q, pending_d;
    logic [7:0]            shift_q, shift_d;

    logic fetching;
    logic col_ok;
    logic blank;
    logic unused_mem_bits;

    assign unused_mem_bits = ^mem_data[15:12];

    assign fetching = (state_q == PRIME) || (state_q == ACTIVE);
    // col_q is the column being fetched; it equals COLUMNS during the last output slot
    assign col_ok   = (col_q < COLS);
    assign blank    = (line_q > 4'd9);

    assign mem_rd   = fetching && (slot_q == 3'd0) && col_ok && !right_pend_q;
    assign mem_addr = mem_rd ? (row_addr_q + ADDR_WIDTH'(col_q)) : '0;
    assign cg_load  = fetching && col_ok && !blank && ((slot_q == 3'd2) || (slot_q == 3'd3));

    assign cg_character_index = idx_q;
    assign cg_xsize           = xsize_q;
    assign cg_ysize           = ysize_q;
    assign cg_xpart           = xpart_q;
    assign cg_ypart           = lower_q & ysize_q;
    assign cg_underline       = uline_q;
    assign cg_invert          = inv_q;
    assign cg_ychar           = ysize_q ? ((line_q >> 1) + (lower_q ? 4'd5 : 4'd0)) : line_q;

    assign busy        = (state_q != IDLE);
    assign line_done   = (state_q == DONE);
    assign pixel_valid = (state_q == ACTIVE);
    assign pixel       = pixel_valid & shift_q[7];

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        col_d        = col_q;
        row_addr_d   = row_addr_q;
        line_d       = line_q;
        lower_d      = lower_q;
        idx_d        = idx_q;
        xsize_d      = xsize_q;
        ysize_d      = ysize_q;
        uline_d      = uline_q;
        inv_d        = inv_q;
        xpart_d      = xpart_q;
        right_pend_d = right_pend_q;
        pending_d    = pending_q;
        shift_d      = shift_q;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d      = PRIME;
                    slot_d       = 3'd0;
                    col_d        = 8'd0;
                    row_addr_d   = row_addr;
                    line_d       = line_in_row;
                    lower_d      = lower_half;
                    right_pend_d = 1'b0;
                end
            end
            PRIME, ACTIVE: begin
                slot_d = slot_q + 3'd1;
                if ((slot_q == 3'd1) && col_ok) begin
                    if (right_pend_q) begin
                        // right half reuses the latched cell; it never opens a new pair
                        xpart_d      = 1'b1;
                        right_pend_d = 1'b0;
                    end else begin
                        idx_d        = mem_data[7:0];
                        xsize_d      = mem_data[8];
                        ysize_d      = mem_data[9];
                        uline_d      = mem_data[10];
                        inv_d        = mem_data[11];
                        xpart_d      = 1'b0;
                        right_pend_d = mem_data[8] && (col_q != COLS - 8'd1);
                    end
                end
                if ((slot_q == 3'd4) && col_ok) begin
                    pending_d = blank ? 8'h00 : cg_row_pixels;
                end
                if (state_q == ACTIVE) begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
                if (slot_q == 3'd7) begin
                    shift_d = pending_q;
                    col_d   = col_q + 8'd1;
                    if (state_q == PRIME) begin
                        state_d = ACTIVE;
                    end else if (col_q == COLS) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                slot_d  = 3'd0;
                col_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            col_q        <= '0;
            row_addr_q   <= '0;
            line_q       <= '0;
            lower_q      <= 1'b0;
            idx_q        <= '0;
            xsize_q      <= 1'b0;
            ysize_q      <= 1'b0;
            uline_q      <= 1'b0;
            inv_q        <= 1'b0;
            xpart_q      <= 1'b0;
            right_pend_q <= 1'b0;
            pending_q    <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            col_q        <= col_d;
            row_addr_q   <= row_addr_d;
            line_q       <= line_d;
            lower_q      <= lower_d;
            idx_q        <= idx_d;
            xsize_q      <= xsize_d;
            ysize_q      <= ysize_d;
            uline_q      <= uline_d;
            inv_q        <= inv_d;
            xpart_q      <= xpart_d;
            right_pend_q <= right_pend_d;
            pending_q    <= pending_d;
            shift_q      <= shift_d;
        end
    end

endmodule

// File: tb/tb_char_row_scheduler.sv
// Scoreboard bench for char_row_scheduler: a cell-level reference model fills
// expectation queues, a negedge monitor pops and compares DUT activity.
module tb_char_row_scheduler;

    localparam int C  = 40;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic [AW-1:0] row_addr = '0;
    logic [3:0]    line_in_row = '0;
    logic          lower_half = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data = '0;
    logic [7:0]    cg_character_index;
    logic [3:0]    cg_ychar;
    logic          cg_xsize, cg_ysize, cg_xpart, cg_ypart, cg_underline, cg_invert;
    logic          cg_load;
    logic [7:0]    cg_row_pixels = '0;
    logic          pixel, pixel_valid, busy, line_done;

    char_row_scheduler #(.COLUMNS(C), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .row_addr(row_addr),
        .line_in_row(line_in_row), .lower_half(lower_half), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_data(mem_data), .cg_character_index(cg_character_index),
        .cg_ychar(cg_ychar), .cg_xsize(cg_xsize), .cg_ysize(cg_ysize), .cg_xpart(cg_xpart),
        .cg_ypart(cg_ypart), .cg_underline(cg_underline), .cg_invert(cg_invert),
        .cg_load(cg_load), .cg_row_pixels(cg_row_pixels), .pixel(pixel),
        .pixel_valid(pixel_valid), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:(1<<AW)-1];
    logic [7:0]  gen_stage = '0;
    int          edge_n = 0;

    // generator vector: {index, ychar, xsize, ysize, xpart, ypart, underline, invert}
    function automatic logic [7:0] gen_f(input logic [17:0] v);
        return v[17:10] ^ {v[9:6], 4'b0} ^ {2'b0, v[5:0]};
    endfunction

    wire [17:0] cg_vec = {cg_character_index, cg_ychar, cg_xsize, cg_ysize,
                          cg_xpart, cg_ypart, cg_underline, cg_invert};

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (mem_rd) mem_data <= mem[mem_addr];
        if (cg_load) begin
            gen_stage     <= gen_f(cg_vec);
            cg_row_pixels <= gen_stage;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    logic [AW-1:0] exp_addr[$];
    logic [17:0]   exp_load[$];
    logic          exp_pix[$];
    int            exp_first, exp_done, pix_cnt;
    bit            done_seen, chk_off = 1'b1;

    // reference model: walks cells by the double-width rules, not by slot timing
    task automatic build_expect(input logic [AW-1:0] row, input logic [3:0] line, input logic lower);
        int c = 0;
        exp_addr.delete(); exp_load.delete(); exp_pix.delete();
        while (c < C) begin
            logic [AW-1:0] a;
            logic [15:0]   d;
            int            parts;
            a = AW'(row + c);
            d = mem[a];
            exp_addr.push_back(a);
            parts = (d[8] && (c + 1 < C)) ? 2 : 1;
            for (int p = 0; p < parts; p++) begin
                logic [3:0]  yc;
                logic [17:0] v;
                logic [7:0]  px;
                yc = d[9] ? 4'((line / 2) + (lower ? 5 : 0)) : line;
                v  = {d[7:0], yc, d[8], d[9], p[0], lower & d[9], d[10], d[11]};
                if (line < 10) begin
                    exp_load.push_back(v);
                    exp_load.push_back(v);
                    px = gen_f(v);
                end else begin
                    px = 8'h00;
                end
                for (int b = 7; b >= 0; b--) exp_pix.push_back(px[b]);
            end
            c += parts;
        end
    endtask

    always @(negedge clk) begin
        if (!chk_off) begin
            if (mem_rd) begin
                if (exp_addr.size() == 0) chk("unexpected_mem_rd", 32'(mem_addr), 32'h0);
                else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (cg_load) begin
                if (exp_load.size() == 0) chk("unexpected_cg_load", 32'(cg_vec), 32'h0);
                else chk("cg_vector", 32'(cg_vec), 32'(exp_load.pop_front()));
            end
            if (pixel_valid) begin
                if (pix_cnt == 0) chk("first_pixel_edge", 32'(edge_n), 32'(exp_first));
                if (exp_pix.size() == 0) chk("unexpected_pixel", 32'(pixel), 32'h0);
                else chk("pixel", 32'(pixel), 32'(exp_pix.pop_front()));
                pix_cnt++;
            end
            if (line_done) begin
                chk("line_done_edge", 32'(edge_n), 32'(exp_done));
                done_seen = 1'b1;
            end
        end
    end

    task automatic start_line(input logic [AW-1:0] row, input logic [3:0] line, input logic lower);
        @(posedge clk); #1;
        build_expect(row, line, lower);
        pix_cnt   = 0;
        done_seen = 1'b0;
        exp_first = edge_n + 1 + 8;
        exp_done  = edge_n + 1 + 8 + 8 * C;
        row_addr = row; line_in_row = line; lower_half = lower;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        row_addr = $urandom; line_in_row = 4'($urandom); lower_half = 1'($urandom);
    endtask

    task automatic finish_line(input string tag, input bit extra_pulse);
        int guard = 0;
        while (!done_seen && guard < 8 * C + 64) begin
            @(posedge clk); #1;
            guard++;
            if (extra_pulse && guard == 50) line_start = 1'b1;
            else line_start = 1'b0;
        end
        line_start = 1'b0;
        if (!done_seen) chk({tag, "_timeout"}, 32'(guard), 32'(8 * C + 9));
        @(posedge clk); #1;
        chk({tag, "_pixel_count"}, 32'(pix_cnt), 32'(8 * C));
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'h0);
        chk({tag, "_load_left"}, 32'(exp_load.size()), 32'h0);
        $display("[TB] line %s done: pixels=%0d", tag, pix_cnt);
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < (1 << AW); i++) mem[i] = v;
    endtask

    initial begin
        fill_mem(16'h0041);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_outputs", 32'({mem_rd, mem_addr, cg_load, cg_vec, pixel, pixel_valid, line_done}), 32'h0);
        reset = 1'b0;
        chk_off = 1'b0;

        start_line(11'h100, 4'd3, 1'b0);
        finish_line("normal", 1'b0);

        mem[11'h105] = 16'h0142;
        start_line(11'h100, 4'd3, 1'b0);
        finish_line("double_width", 1'b0);

        fill_mem(16'h0041);
        mem[11'h100 + 39] = 16'h0141;
        start_line(11'h100, 4'd3, 1'b0);
        finish_line("clip", 1'b0);

        fill_mem(16'h0241);
        start_line(11'h200, 4'd7, 1'b1);
        finish_line("dheight_lower", 1'b0);
        start_line(11'h200, 4'd7, 1'b0);
        finish_line("dheight_upper", 1'b0);

        fill_mem(16'h0041);
        start_line(11'h7FE, 4'd3, 1'b0);
        finish_line("wrap", 1'b0);
        start_line(11'h010, 4'd12, 1'b0);
        finish_line("blank", 1'b0);

        start_line(11'h100, 4'd3, 1'b0);
        finish_line("busy_pulse", 1'b1);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < (1 << AW); i++) begin
                logic [15:0] r;
                r = 16'($urandom);
                r[8] = ($urandom_range(0, 3) == 0);
                mem[i] = r;
            end
            start_line(AW'($urandom), 4'($urandom_range(0, 11)), 1'($urandom));
            finish_line("random", 1'b0);
        end

        // reset in the middle of a line
        start_line(11'h100, 4'd3, 1'b0);
        begin
            int guard = 0;
            bit done_after;
            while (pix_cnt < 100 && guard < 1000) begin
                @(posedge clk);
                guard++;
            end
            #1;
            chk_off = 1'b1;
            reset = 1'b1;
            @(negedge clk);
            chk("midreset_outputs", 32'({busy, pixel_valid, mem_rd, line_done}), 32'h0);
            @(posedge clk); #1;
            reset = 1'b0;
            done_after = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (line_done || busy) done_after = 1'b1;
            end
            chk("midreset_no_line_done", 32'(done_after), 32'h0);
            $display("[TB] mid-line reset applied after %0d pixels", pix_cnt);
            chk_off = 1'b0;
        end

        start_line(11'h100, 4'd3, 1'b0);
        finish_line("after_reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_row_scheduler.md
Name: char_row_scheduler

Overview:
- Sequences the character generator for one displayed scanline of a text row.
- Per character cell it fetches the cell word from video memory, resolves double-width and double-height parts, and drives the generator inputs with two load strobes.
- It captures the resulting 8-pixel row and serialises it one pixel per clock.
- Sits between the line/timing controller (upstream) and the pixel colour stage (downstream); it prefetches one cell ahead so pixel output is gapless.

Parameters:
COLUMNS, 40, character cells per text row (1..127)
ADDR_WIDTH, 11, video memory address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse: render one scanline; ignored while busy=1
row_addr  in  ADDR_WIDTH  memory address of column 0 of the text row
line_in_row  in  4  scanline within the character cell, 0..9
lower_half  in  1  1 = this text row is the lower half of a double-height row
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  read address = row_addr + column (mod 2^ADDR_WIDTH)
mem_data  in  16  read data, valid the cycle after mem_rd; [7:0] index, [8] xsize, [9] ysize, [10] underline, [11] invert, [15:12] ignored
cg_character_index  out  8  to generator
cg_ychar  out  4  to generator
cg_xsize, cg_ysize, cg_xpart, cg_ypart, cg_underline, cg_invert  out  1 each  to generator
cg_load  out  1  generator load enable
cg_row_pixels  in  8  generator output (registered in generator)
pixel  out  1  serial pixel, MSB of row first
pixel_valid  out  1  pixel is an active display pixel
busy  out  1  line in progress
line_done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset: all outputs 0; FSM in IDLE; slot counter, column counter, shift and pending registers 0.
- FSM states: IDLE -> PRIME on line_start. PRIME -> ACTIVE after one 8-cycle slot. ACTIVE -> DONE after COLUMNS slots. DONE -> IDLE after one cycle.
- busy is 1 in PRIME, ACTIVE and DONE.
- line_done is 1 only in DONE.
- line_start is sampled at edge T. The prime slot occupies cycles T+1..T+8, pixels occupy T+9..T+8+8*COLUMNS, and line_done occurs on the following cycle.
- Slot counter s runs 0..7 per slot. Fetch of cell k+1 overlaps output of cell k:
  - s0: mem_rd=1, mem_addr=row_addr+next column (skipped, see double width).
  - s1: latch mem_data into the cell register.
  - s2 and s3: cg_load=1, with cg_* held stable through both pulses. The generator needs two loads to propagate.
  - s4: capture cg_row_pixels into the pending register.
  - End of s7: pending -> shift register.
- In PRIME and the ACTIVE slots, fetches target the next column. No fetch occurs in the final ACTIVE slot (next column == COLUMNS).
- Serialisation: pixel = shift[7], shifting left each cycle in ACTIVE; pixel_valid=1 only in ACTIVE. The pending value captured for cell k is emitted in slot k+1.
- Double width: if a fetched cell has xsize=1 and the current part is left, that cell drives cg_xpart=0.
  - The next column issues no mem_rd. It reuses the latched index and attributes with cg_xpart=1.
  - The column after it fetches normally.
  - If xsize=1 on column COLUMNS-1, the right half is dropped (clipped).
  - A right-half cell never starts a new pair.
- Double height: cg_ysize=ysize. cg_ypart = lower_half & ysize.
  - If ysize=1: cg_ychar = (line_in_row>>1) + (lower_half ? 5 : 0).
  - Otherwise: cg_ychar = line_in_row.
- row_addr, line_in_row and lower_half are registered on line_start and held for the whole line.
- line_in_row of 10..15: no cg_load is issued and pending is forced to 8'h00 (blank line).
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset asserted mid-line: immediate return to the reset state, with no line_done. The next line_start after release starts cleanly.

Test Plan:
- Normal line: row_addr=0x100, line_in_row=3, all cells 16'h0041, COLUMNS=40, generator model returning 0xA5.
  - mem_addr steps 0x100..0x127, one mem_rd per slot, cg_load high at s2 and s3 of each slot.
  - pixel_valid high for exactly 320 cycles starting T+9; line_done at T+329.
  - Each cell emits 1,0,1,0,0,1,0,1.
- Double width at column 5 (data 16'h0142):
  - No mem_rd for address row_addr+6.
  - Column 6 drives cg_character_index=0x42 and cg_xpart=1.
  - Column 7 reads row_addr+7 normally.
- Clipping: xsize=1 on column 39 -> column 39 drives xpart=0; pixel_valid ends after 320 cycles; no extra fetch.
- Double height: ysize=1, line_in_row=7, lower_half=1 -> cg_ychar=8, cg_ypart=1. With lower_half=0 -> cg_ychar=3, cg_ypart=0.
- Wrap and blank: row_addr=0x7FE -> addresses 0x7FE, 0x7FF, 0x000.... line_in_row=12 -> no cg_load; all pixels 0 with pixel_valid=1.
- Robustness:
  - line_start pulsed while busy -> ignored; the line still completes at T+329.
  - reset asserted at pixel 100 -> next cycle busy=0, pixel_valid=0, mem_rd=0, no line_done.
